// File: rtl/rx_deserializer_if.sv
// Link-side bundle of the receive deserializer: serial line in, word handshake out to the Core.
// Optional err_count exists only when RX_ERRCNT_EN is defined.
interface rx_deserializer_if #(
  parameter int unsigned DataW = 32
);
  logic             s_data;
  logic             rx_ready;
  logic             rx_error;
  logic [DataW-1:0] rx_data;
  logic             rx_data_valid;
  logic             rx_data_ack;
`ifdef RX_ERRCNT_EN
  logic [7:0]       err_count;

  modport master (
    input  s_data, rx_data_ack,
    output rx_ready, rx_error, rx_data, rx_data_valid, err_count
  );
  modport slave (
    output s_data, rx_data_ack,
    input  rx_ready, rx_error, rx_data, rx_data_valid, err_count
  );
`else
  modport master (
    input  s_data, rx_data_ack,
    output rx_ready, rx_error, rx_data, rx_data_valid
  );
  modport slave (
    output s_data, rx_data_ack,
    input  rx_ready, rx_error, rx_data, rx_data_valid
  );
`endif
endinterface

// File: rtl/rx_deserializer.sv
// Serial link receiver: start-sequence hunt, 1-unstuffing, odd-parity check, valid/ack word handoff.
// Define RX_ERRCNT_EN to add a saturating 8-bit error counter on link.err_count.
module rx_deserializer #(
  parameter int unsigned DataW    = 32,
  parameter int unsigned StartLen = 5,
  parameter int unsigned StuffRun = 4
) (
  input logic               clk_s,
  input logic               rst,
  rx_deserializer_if.master link
);

  localparam int unsigned FrameLen = DataW + 1;

  typedef enum logic [1:0] {StIdle, StData, StCheck, StHold} state_e;

  state_e           state_q, state_d;
  logic [2:0]       zrun_q, zrun_d;
  logic [5:0]       bit_cnt_q, bit_cnt_d;
  logic [2:0]       zero_cnt_q, zero_cnt_d;
  logic [DataW:0]   shift_q, shift_d;
  logic [DataW:0]   shift_in;
  logic [DataW:0]   frame;
  logic             frame_done;
  logic             ready_q, ready_d;
  logic             error_q, error_d;
  logic             valid_q, valid_d;
  logic [DataW-1:0] data_q, data_d;

  always_ff @(posedge clk_s or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      zrun_q     <= '0;
      bit_cnt_q  <= '0;
      zero_cnt_q <= '0;
      shift_q    <= '0;
      ready_q    <= 1'b1;
      error_q    <= 1'b0;
      valid_q    <= 1'b0;
      data_q     <= '0;
    end else begin
      state_q    <= state_d;
      zrun_q     <= zrun_d;
      bit_cnt_q  <= bit_cnt_d;
      zero_cnt_q <= zero_cnt_d;
      shift_q    <= shift_d;
      ready_q    <= ready_d;
      error_q    <= error_d;
      valid_q    <= valid_d;
      data_q     <= data_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    zrun_d     = zrun_q;
    bit_cnt_d  = bit_cnt_q;
    zero_cnt_d = zero_cnt_q;
    shift_d    = shift_q;
    valid_d    = valid_q;
    data_d     = data_q;
    error_d    = 1'b0;
    shift_in   = {shift_q[DataW-1:0], link.s_data};
    frame      = shift_q;
    frame_done = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (link.s_data) begin
          zrun_d = '0;
        end else if (zrun_q == 3'(StartLen - 1)) begin
          state_d    = StData;
          zrun_d     = '0;
          bit_cnt_d  = '0;
          zero_cnt_d = '0;
        end else begin
          zrun_d = zrun_q + 3'd1;
        end
      end
      StData: begin
        if (zero_cnt_q == 3'(StuffRun)) begin
          zero_cnt_d = '0;
          if (!link.s_data) begin
            error_d = 1'b1;
            state_d = StIdle;
          end else if (bit_cnt_q == 6'(FrameLen)) begin
            // Trailing stuff bit after a parity-completed zero run.
            frame_done = 1'b1;
          end
        end else begin
          shift_d    = shift_in;
          bit_cnt_d  = bit_cnt_q + 6'd1;
          zero_cnt_d = link.s_data ? 3'd0 : zero_cnt_q + 3'd1;
          if (bit_cnt_q == 6'(FrameLen - 1) && zero_cnt_d != 3'(StuffRun)) begin
            frame      = shift_in;
            frame_done = 1'b1;
          end
        end
      end
      StCheck: begin
        if (valid_q && !link.rx_data_ack) begin
          state_d = StHold;
        end else begin
          state_d = StIdle;
          valid_d = 1'b0;
        end
      end
      StHold: begin
        if (link.rx_data_ack) begin
          state_d = StIdle;
          valid_d = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase

    // Outputs land in the cycle after the last line bit, which is the CHECK cycle.
    if (frame_done) begin
      state_d = StCheck;
      if (^frame) begin
        data_d  = frame[DataW:1];
        valid_d = 1'b1;
      end else begin
        error_d = 1'b1;
      end
    end

    ready_d = (state_d == StIdle);
  end

  assign link.rx_ready      = ready_q;
  assign link.rx_error      = error_q;
  assign link.rx_data       = data_q;
  assign link.rx_data_valid = valid_q;

`ifdef RX_ERRCNT_EN
  logic [7:0] err_cnt_q;

  always_ff @(posedge clk_s or posedge rst) begin
    if (rst) begin
      err_cnt_q <= '0;
    end else if (error_d && err_cnt_q != 8'hFF) begin
      err_cnt_q <= err_cnt_q + 8'd1;
    end
  end

  assign link.err_count = err_cnt_q;
`endif

endmodule

// File: tb/tb_rx_deserializer.sv
// Directed bench for rx_deserializer: table of frames plus idle, stuff-error and reset-abort sequences.
module tb_rx_deserializer;

  localparam int unsigned DataW = 32;

  typedef struct {
    logic [31:0] payload;
    logic        parity;
    logic        pass;
    logic [31:0] exp_data;
  } vec_t;

  logic clk_s = 1'b0;
  logic rst   = 1'b1;
  always #5 clk_s = ~clk_s;

  rx_deserializer_if #(.DataW(DataW)) link ();

  rx_deserializer #(
    .DataW   (DataW),
    .StartLen(5),
    .StuffRun(4)
  ) dut (
    .clk_s(clk_s),
    .rst  (rst),
    .link (link)
  );

  int          n_vec = 0;
  int          n_bad = 0;
  int          exp_err = 0;
  logic [31:0] last_good = '0;
  logic        line_q[$];
  vec_t        vecs[7];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic check_errcnt(input string nm);
`ifdef RX_ERRCNT_EN
    check(nm, 32'(link.err_count), 32'(exp_err));
`endif
  endtask

  task automatic drive(input logic b);
    @(negedge clk_s);
    link.s_data = b;
  endtask

  task automatic send_start();
    repeat (5) drive(1'b0);
  endtask

  // Expected line image: payload MSb first, parity, a 1 after every run of 4 zeros.
  task automatic build_line(input logic [31:0] payload, input logic parity);
    logic [32:0] word;
    int          zeros;
    word  = {payload, parity};
    zeros = 0;
    line_q.delete();
    for (int i = 32; i >= 0; i--) begin
      line_q.push_back(word[i]);
      zeros = word[i] ? 0 : zeros + 1;
      if (zeros == 4) begin
        line_q.push_back(1'b1);
        zeros = 0;
      end
    end
  endtask

  task automatic run_frame(input vec_t v, input int idx);
    string tag;
    tag = $sformatf("vec%0d", idx);
    build_line(v.payload, v.parity);
    check({tag, "_ready_pre"}, 32'(link.rx_ready), 32'd1);
    send_start();
    for (int i = 0; i < line_q.size(); i++) begin
      drive(line_q[i]);
      if (i == 0) check({tag, "_ready_busy"}, 32'(link.rx_ready), 32'd0);
    end
    @(negedge clk_s);
    link.s_data = 1'b1;
    check({tag, "_valid"}, 32'(link.rx_data_valid), 32'(v.pass));
    check({tag, "_error"}, 32'(link.rx_error), 32'(!v.pass));
    check({tag, "_ready_chk"}, 32'(link.rx_ready), 32'd0);
    if (v.pass) begin
      check({tag, "_data"}, link.rx_data, v.exp_data);
      last_good = v.exp_data;
      repeat (2) @(negedge clk_s);
      check({tag, "_hold_valid"}, 32'(link.rx_data_valid), 32'd1);
      check({tag, "_hold_data"}, link.rx_data, v.exp_data);
      link.rx_data_ack = 1'b1;
      @(negedge clk_s);
      link.rx_data_ack = 1'b0;
      check({tag, "_valid_drop"}, 32'(link.rx_data_valid), 32'd0);
      check({tag, "_ready_post"}, 32'(link.rx_ready), 32'd1);
    end else begin
      exp_err++;
      check({tag, "_data_kept"}, link.rx_data, last_good);
      check_errcnt({tag, "_errcnt"});
      @(negedge clk_s);
      check({tag, "_error_pulse"}, 32'(link.rx_error), 32'd0);
      check({tag, "_ready_post"}, 32'(link.rx_ready), 32'd1);
    end
  endtask

  initial begin
    vecs[0] = '{32'hA5A5A5A5, 1'b1, 1'b1, 32'hA5A5A5A5};
    vecs[1] = '{32'h00000000, 1'b1, 1'b1, 32'h00000000};
    vecs[2] = '{32'h00000001, 1'b1, 1'b0, 32'h00000000};
    vecs[3] = '{32'h12345678, 1'b0, 1'b1, 32'h12345678};
    vecs[4] = '{32'hFFFFFFFF, 1'b1, 1'b1, 32'hFFFFFFFF};
    vecs[5] = '{32'h80000000, 1'b0, 1'b1, 32'h80000000};
    vecs[6] = '{32'hFFFFFFFF, 1'b0, 1'b0, 32'h00000000};

    link.s_data      = 1'b1;
    link.rx_data_ack = 1'b0;
    rst              = 1'b1;
    repeat (3) @(negedge clk_s);
    check("rst_ready", 32'(link.rx_ready), 32'd1);
    check("rst_valid", 32'(link.rx_data_valid), 32'd0);
    check("rst_error", 32'(link.rx_error), 32'd0);
    check("rst_data", link.rx_data, 32'd0);
    check_errcnt("rst_errcnt");
    rst = 1'b0;

    // Idle line
    repeat (20) begin
      drive(1'b1);
      check("idle", {29'd0, link.rx_ready, link.rx_data_valid, link.rx_error}, 32'b100);
    end

    // Ack with nothing pending is ignored
    @(negedge clk_s);
    link.rx_data_ack = 1'b1;
    @(negedge clk_s);
    link.rx_data_ack = 1'b0;
    check("stray_ack", {30'd0, link.rx_ready, link.rx_data_valid}, 32'b10);

    foreach (vecs[i]) run_frame(vecs[i], i);

    // Zero in the stuff slot after four payload zeros
    send_start();
    repeat (4) drive(1'b0);
    drive(1'b0);
    @(negedge clk_s);
    link.s_data = 1'b1;
    exp_err++;
    check("stuff_error", 32'(link.rx_error), 32'd1);
    check("stuff_valid", 32'(link.rx_data_valid), 32'd0);
    check("stuff_ready", 32'(link.rx_ready), 32'd1);
    check("stuff_data", link.rx_data, last_good);
    check_errcnt("stuff_errcnt");
    @(negedge clk_s);
    check("stuff_error_pulse", 32'(link.rx_error), 32'd0);

    // Reset partway through a frame
    build_line(32'h12345678, 1'b0);
    send_start();
    for (int i = 0; i < 17; i++) drive(line_q[i]);
    @(negedge clk_s);
    rst         = 1'b1;
    link.s_data = 1'b1;
    @(negedge clk_s);
    exp_err   = 0;
    last_good = '0;
    check("abort_valid", 32'(link.rx_data_valid), 32'd0);
    check("abort_error", 32'(link.rx_error), 32'd0);
    check("abort_ready", 32'(link.rx_ready), 32'd1);
    check("abort_data", link.rx_data, 32'd0);
    check_errcnt("abort_errcnt");
    rst = 1'b0;
    repeat (3) drive(1'b1);
    check("abort_quiet", {30'd0, link.rx_data_valid, link.rx_error}, 32'd0);
    run_frame(vecs[3], 7);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
